// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - FSM states, word width and geometry helpers for rle_enc
package rle_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SCAN,
    ST_EMIT,
    ST_FLUSH,
    ST_FIN
  } rle_state_t;

  function automatic int pair_width(input int sym_w, input int cnt_w);
    return sym_w + cnt_w;
  endfunction

  function automatic int pairs_per_word(input int sym_w, input int cnt_w);
    return WORD_W / (sym_w + cnt_w);
  endfunction

  function automatic int syms_per_word(input int sym_w);
    return WORD_W / sym_w;
  endfunction

  function automatic int max_count(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

  function automatic bit params_legal(input int sym_w, input int cnt_w);
    return ((sym_w == 8) || (sym_w == 16)) &&
           (((sym_w + cnt_w) == 16) || ((sym_w + cnt_w) == 32));
  endfunction

endpackage

// File: rtl/rle_packer.sv
// rtl/rle_packer.sv - packs {symbol,count} pairs into a zero-padded 32-bit word
// clear/push/pair   : empty the word / append pair at the next slot
// tail_valid/_pair  : pair merged into word combinationally (final flush)
// word              : packed word, unused slots zero
// full/last_slot    : all slots used / exactly one slot left
// not_empty         : at least one pair held
module rle_packer
  import rle_pkg::*;
#(
  parameter int PW  = 16,
  parameter int PPW = 2
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          clear,
  input  logic          push,
  input  logic [PW-1:0] pair,
  input  logic          tail_valid,
  input  logic [PW-1:0] tail_pair,
  output logic [31:0]   word,
  output logic          full,
  output logic          last_slot,
  output logic          not_empty
);

  localparam int CW = $clog2(PPW + 1);

  logic [WORD_W-1:0] word_q;
  logic [CW-1:0]     cnt_q;
  int                shamt;

  assign shamt = int'(cnt_q) * PW;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (clear) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (push) begin
      word_q <= word_q | (32'(pair) << shamt);
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  // Slots are cleared on every pop, so empty slots already read as zero padding.
  assign word      = tail_valid ? (word_q | (32'(tail_pair) << shamt)) : word_q;
  assign full      = (cnt_q == CW'(PPW));
  assign last_slot = (cnt_q == CW'(PPW - 1));
  assign not_empty = (cnt_q != '0);

endmodule

// File: rtl/rle_enc.sv
// rtl/rle_enc.sv - run-length encoder reading and writing a shared single-port dpsram
// start/message_addr/message_size/rle_addr : frame request (sampled when idle)
// rle_size/busy/done                       : progress and completion status
// port_A_*                                 : dpsram port, 1-cycle read latency
module rle_enc
  import rle_pkg::*;
#(
  parameter int SYM_W  = 8,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       message_size,
  input  logic [31:0]       rle_addr,
  output logic [31:0]       rle_size,
  output logic              busy,
  output logic              done,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out
);

  localparam int PW        = pair_width(SYM_W, CNT_W);
  localparam int PPW       = pairs_per_word(SYM_W, CNT_W);
  localparam int SPW       = syms_per_word(SYM_W);
  localparam int SIW       = $clog2(SPW);
  localparam int SYM_SHIFT = (SYM_W == 16) ? 1 : 0;
  localparam logic [CNT_W-1:0] MAXC = CNT_W'(max_count(CNT_W));

  if (!params_legal(SYM_W, CNT_W)) begin : g_bad_params
    $error("rle_enc: SYM_W must be 8 or 16 and SYM_W+CNT_W must be 16 or 32");
  end

  rle_state_t        state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [31:0]       cur_word_q;
  logic [SIW-1:0]    sym_idx_q;
  logic [31:0]       syms_left_q;
  logic [SYM_W-1:0]  run_sym_q;
  logic [CNT_W-1:0]  run_cnt_q;
  logic              run_open_q;
  logic [31:0]       rle_size_q;
  logic              busy_q, done_q;

  logic [31:0]       nsyms;
  logic [SYM_W-1:0]  cur_sym;
  logic              extend, pk_push, word_end;
  logic              pk_clear, pk_tail_valid;
  logic [31:0]       pk_word;
  logic              pk_full, pk_last_slot, pk_not_empty;
  logic [PW-1:0]     run_pair;
  logic              unused_inputs;

  // Address bits outside the word-aligned window and odd size bits carry no meaning.
  assign unused_inputs = ^{message_addr, rle_addr, message_size};

  assign nsyms    = message_size >> SYM_SHIFT;
  assign cur_sym  = SYM_W'(cur_word_q >> (int'(sym_idx_q) * SYM_W));
  assign extend   = run_open_q && (cur_sym == run_sym_q) && (run_cnt_q != MAXC);
  assign pk_push  = (state_q == ST_SCAN) && run_open_q && !extend;
  assign word_end = (sym_idx_q == SIW'(SPW - 1));
  assign run_pair = {run_sym_q, run_cnt_q};

  rle_packer #(
    .PW (PW),
    .PPW(PPW)
  ) u_packer (
    .clk       (clk),
    .nreset    (nreset),
    .clear     (pk_clear),
    .push      (pk_push),
    .pair      (run_pair),
    .tail_valid(pk_tail_valid),
    .tail_pair (run_pair),
    .word      (pk_word),
    .full      (pk_full),
    .last_slot (pk_last_slot),
    .not_empty (pk_not_empty)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    port_A_we      = 1'b0;
    port_A_addr    = rd_addr_q;
    port_A_data_in = '0;
    pk_clear       = 1'b0;
    pk_tail_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pk_clear = 1'b1;
          state_d  = (nsyms == '0) ? ST_FIN : ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SCAN;
      ST_SCAN: begin
        // A pair landing in the last free slot must be written before the
        // next symbol can close another run.
        if (pk_push && pk_last_slot)      state_d = ST_EMIT;
        else if (syms_left_q == 32'd1)    state_d = ST_FLUSH;
        else if (word_end)                state_d = ST_FETCH;
      end
      ST_EMIT: begin
        port_A_we      = pk_full;
        port_A_addr    = wr_addr_q;
        port_A_data_in = pk_word;
        pk_clear       = 1'b1;
        // sym_idx has wrapped to 0 when the emitting symbol ended its word.
        if (syms_left_q == '0)         state_d = ST_FLUSH;
        else if (sym_idx_q == '0)      state_d = ST_FETCH;
        else                           state_d = ST_SCAN;
      end
      ST_FLUSH: begin
        pk_tail_valid = run_open_q;
        port_A_we     = run_open_q || pk_not_empty;
        port_A_addr   = wr_addr_q;
        if (port_A_we) port_A_data_in = pk_word;
        pk_clear      = 1'b1;
        state_d       = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      cur_word_q  <= '0;
      sym_idx_q   <= '0;
      syms_left_q <= '0;
      run_sym_q   <= '0;
      run_cnt_q   <= '0;
      run_open_q  <= 1'b0;
      rle_size_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rd_addr_q   <= {message_addr[ADDR_W-1:2], 2'b00};
            wr_addr_q   <= {rle_addr[ADDR_W-1:2], 2'b00};
            syms_left_q <= nsyms;
            sym_idx_q   <= '0;
            run_open_q  <= 1'b0;
            rle_size_q  <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
          end
        end
        ST_LOAD: begin
          cur_word_q <= port_A_data_out;
          rd_addr_q  <= rd_addr_q + ADDR_W'(4);
        end
        ST_SCAN: begin
          syms_left_q <= syms_left_q - 32'd1;
          sym_idx_q   <= sym_idx_q + SIW'(1);
          if (extend) begin
            run_cnt_q <= run_cnt_q + CNT_W'(1);
          end else begin
            run_sym_q  <= cur_sym;
            run_cnt_q  <= CNT_W'(1);
            run_open_q <= 1'b1;
          end
        end
        ST_EMIT, ST_FLUSH: begin
          if (port_A_we) begin
            wr_addr_q  <= wr_addr_q + ADDR_W'(4);
            rle_size_q <= rle_size_q + 32'd4;
          end
          if (state_q == ST_FLUSH) run_open_q <= 1'b0;
        end
        ST_FIN: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rle_size   = rle_size_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign port_A_clk = clk;

endmodule

// File: tb/tb_rle_enc.sv
// tb/tb_rle_enc.sv - directed self-checking bench for rle_enc (8/8 and 16/16 configurations)
module tb_rle_enc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nreset = 1'b0;

  logic        start_a = 1'b0;
  logic [31:0] maddr_a = '0, msize_a = '0, raddr_a = '0;
  logic [31:0] rle_size_a, din_a, dout_a;
  logic        busy_a, done_a, pclk_a, we_a;
  logic [15:0] addr_a;

  logic        start_b = 1'b0;
  logic [31:0] maddr_b = '0, msize_b = '0, raddr_b = '0;
  logic [31:0] rle_size_b, din_b, dout_b;
  logic        busy_b, done_b, pclk_b, we_b;
  logic [15:0] addr_b;

  rle_enc dut_a (
    .clk(clk), .nreset(nreset), .start(start_a),
    .message_addr(maddr_a), .message_size(msize_a), .rle_addr(raddr_a),
    .rle_size(rle_size_a), .busy(busy_a), .done(done_a),
    .port_A_clk(pclk_a), .port_A_addr(addr_a), .port_A_we(we_a),
    .port_A_data_in(din_a), .port_A_data_out(dout_a)
  );

  rle_enc #(.SYM_W(16), .CNT_W(16)) dut_b (
    .clk(clk), .nreset(nreset), .start(start_b),
    .message_addr(maddr_b), .message_size(msize_b), .rle_addr(raddr_b),
    .rle_size(rle_size_b), .busy(busy_b), .done(done_b),
    .port_A_clk(pclk_b), .port_A_addr(addr_b), .port_A_we(we_b),
    .port_A_data_in(din_b), .port_A_data_out(dout_b)
  );

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic        tb_wr_a = 1'b0, tb_wr_b = 1'b0, tb_clr = 1'b0;
  logic [7:0]  tb_idx = '0;
  logic [31:0] tb_dat = '0;
  int          wcnt_a = 0, wcnt_b = 0;

  always @(posedge pclk_a) begin
    if (tb_wr_a) mem_a[tb_idx] <= tb_dat;
    else if (we_a) mem_a[addr_a[9:2]] <= din_a;
    dout_a <= mem_a[addr_a[9:2]];
    if (tb_clr) wcnt_a <= 0;
    else if (we_a) wcnt_a <= wcnt_a + 1;
  end

  always @(posedge pclk_b) begin
    if (tb_wr_b) mem_b[tb_idx] <= tb_dat;
    else if (we_b) mem_b[addr_b[9:2]] <= din_b;
    dout_b <= mem_b[addr_b[9:2]];
    if (tb_clr) wcnt_b <= 0;
    else if (we_b) wcnt_b <= wcnt_b + 1;
  end

  int errors = 0;
  int checks = 0;
  int cyc;

  localparam logic [31:0] SENT = 32'hDEADBEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_a(input int idx, input logic [31:0] d);
    @(negedge clk);
    tb_wr_a = 1'b1; tb_idx = 8'(idx); tb_dat = d;
    @(negedge clk);
    tb_wr_a = 1'b0;
  endtask

  task automatic load_b(input int idx, input logic [31:0] d);
    @(negedge clk);
    tb_wr_b = 1'b1; tb_idx = 8'(idx); tb_dat = d;
    @(negedge clk);
    tb_wr_b = 1'b0;
  endtask

  // Returns in the first cycle after start is accepted.
  task automatic kick_a(input logic [31:0] ma, input logic [31:0] ms, input logic [31:0] ra);
    @(negedge clk);
    maddr_a = ma; msize_a = ms; raddr_a = ra; start_a = 1'b1; tb_clr = 1'b1;
    @(negedge clk);
    start_a = 1'b0; tb_clr = 1'b0;
  endtask

  task automatic kick_b(input logic [31:0] ma, input logic [31:0] ms, input logic [31:0] ra);
    @(negedge clk);
    maddr_b = ma; msize_b = ms; raddr_b = ra; start_b = 1'b1; tb_clr = 1'b1;
    @(negedge clk);
    start_b = 1'b0; tb_clr = 1'b0;
  endtask

  // Counts cycles since acceptance until done; at cycle 'inject' a bogus
  // start (zero size, other output address) is pulsed while the frame is busy.
  task automatic wait_a(input int inject, output int c);
    c = 1;
    while (done_a !== 1'b1 && c < 2000) begin
      start_a = (c == inject);
      if (c == inject) begin
        msize_a = 32'd0;
        raddr_a = 32'h300;
      end
      @(negedge clk);
      c++;
    end
    start_a = 1'b0;
  endtask

  task automatic wait_b(output int c);
    c = 1;
    while (done_b !== 1'b1 && c < 2000) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy_a), 32'd0);
    chk("reset_done", 32'(done_a), 32'd0);
    chk("reset_rle_size", rle_size_a, 32'd0);
    chk("reset_we", 32'(we_a), 32'd0);
    chk("reset_addr", 32'(addr_a), 32'd0);
    chk("reset_data_in", din_a, 32'd0);
    nreset = 1'b1;

    // single run of four identical bytes
    load_a(16, 32'h41414141);
    load_a(64, SENT);
    load_a(65, SENT);
    kick_a(32'h40, 32'd4, 32'h100);
    chk("t1_busy", 32'(busy_a), 32'd1);
    chk("t1_fetch_addr", 32'(addr_a), 32'h40);
    chk("t1_done_low", 32'(done_a), 32'd0);
    wait_a(-1, cyc);
    chk("t1_latency", 32'(cyc), 32'd9);
    chk("t1_word0", mem_a[64], 32'h00004104);
    chk("t1_no_word1", mem_a[65], SENT);
    chk("t1_writes", 32'(wcnt_a), 32'd1);
    chk("t1_rle_size", rle_size_a, 32'd4);
    chk("t1_busy_end", 32'(busy_a), 32'd0);

    // four distinct bytes, restart after done, ignored start while busy
    load_a(16, 32'h44332211);
    load_a(64, SENT);
    load_a(65, SENT);
    load_a(66, SENT);
    kick_a(32'h40, 32'd4, 32'h100);
    chk("t2_done_drop", 32'(done_a), 32'd0);
    wait_a(3, cyc);
    chk("t2_latency", 32'(cyc), 32'd10);
    chk("t2_word0", mem_a[64], 32'h22011101);
    chk("t2_word1", mem_a[65], 32'h44013301);
    chk("t2_no_word2", mem_a[66], SENT);
    chk("t2_writes", 32'(wcnt_a), 32'd2);
    chk("t2_rle_size", rle_size_a, 32'd8);

    // 300-symbol run saturates at 255 and splits
    for (int i = 0; i < 75; i++) load_a(i, 32'hAAAAAAAA);
    load_a(128, SENT);
    load_a(129, SENT);
    kick_a(32'h0, 32'd300, 32'h200);
    wait_a(-1, cyc);
    chk("t3_word0", mem_a[128], 32'hAA2DAAFF);
    chk("t3_no_word1", mem_a[129], SENT);
    chk("t3_writes", 32'(wcnt_a), 32'd1);
    chk("t3_rle_size", rle_size_a, 32'd4);

    // one-byte frame: upper bytes of the word ignored, pad zero
    load_a(16, 32'hFFFFFFAB);
    load_a(64, SENT);
    load_a(65, SENT);
    kick_a(32'h40, 32'd1, 32'h100);
    wait_a(-1, cyc);
    chk("t4_latency", 32'(cyc), 32'd6);
    chk("t4_word0", mem_a[64], 32'h0000AB01);
    chk("t4_no_word1", mem_a[65], SENT);
    chk("t4_rle_size", rle_size_a, 32'd4);

    // zero-size frame
    kick_a(32'h40, 32'd0, 32'h100);
    wait_a(-1, cyc);
    chk("t5_latency", 32'(cyc), 32'd2);
    chk("t5_writes", 32'(wcnt_a), 32'd0);
    chk("t5_rle_size", rle_size_a, 32'd0);
    chk("t5_done", 32'(done_a), 32'd1);

    // reset while scanning
    load_a(128, SENT);
    kick_a(32'h0, 32'd300, 32'h200);
    repeat (4) @(negedge clk);
    nreset = 1'b0;
    #1;
    chk("t6_busy", 32'(busy_a), 32'd0);
    chk("t6_done", 32'(done_a), 32'd0);
    chk("t6_rle_size", rle_size_a, 32'd0);
    chk("t6_we", 32'(we_a), 32'd0);
    chk("t6_addr", 32'(addr_a), 32'd0);
    chk("t6_data_in", din_a, 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    repeat (30) @(negedge clk);
    chk("t6_no_writes", 32'(wcnt_a), 32'd0);
    chk("t6_idle", 32'(busy_a), 32'd0);
    chk("t6_untouched", mem_a[128], SENT);

    // frame after reset
    load_a(16, 32'h41414141);
    load_a(64, SENT);
    kick_a(32'h40, 32'd4, 32'h100);
    wait_a(-1, cyc);
    chk("t7_word0", mem_a[64], 32'h00004104);
    chk("t7_rle_size", rle_size_a, 32'd4);

    // 16-bit symbols, 16-bit counts, one pair per word
    load_b(16, 32'h00050005);
    load_b(17, 32'h00000007);
    load_b(64, SENT);
    load_b(65, SENT);
    load_b(66, SENT);
    kick_b(32'h40, 32'd6, 32'h100);
    wait_b(cyc);
    chk("t8_latency", 32'(cyc), 32'd11);
    chk("t8_word0", mem_b[64], 32'h00050002);
    chk("t8_word1", mem_b[65], 32'h00070001);
    chk("t8_no_word2", mem_b[66], SENT);
    chk("t8_writes", 32'(wcnt_b), 32'd2);
    chk("t8_rle_size", rle_size_b, 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rle_enc.md
# rle_enc

Parametrised run-length encoder, successor to the 8-bit `rle` block. It reads a plaintext frame from the shared single-port dpsram and writes `{symbol, count}` pairs back into the same memory. Over the first generation it adds:
- configurable symbol and count widths;
- run splitting when a count saturates;
- correct partial-word tail handling;
- zero-padded final output word;
- a start/busy/done handshake that supports restart.

## Interface
Parameters:
- `SYM_W`, 8, symbol width in bits; legal values 8 or 16.
- `CNT_W`, 8, run-count width in bits; `SYM_W+CNT_W` must be 16 or 32 (elaboration error otherwise).
- `ADDR_W`, 16, dpsram address width.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `nreset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; sampled only when not busy.
- `message_addr`  in  32  byte address of plaintext; bits [1:0] ignored.
- `message_size`  in  32  plaintext length in bytes; multiple of SYM_W/8.
- `rle_addr`  in  32  byte address of output; bits [1:0] ignored.
- `rle_size`  out  32  bytes written so far; final when `done`.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  level; high after completion until the next accepted `start`.
- `port_A_clk`  out  1  equals `clk`.
- `port_A_addr`  out  ADDR_W  read/write word address (byte units, step 4).
- `port_A_we`  out  1  write strobe, one cycle per output word.
- `port_A_data_in`  out  32  write data.
- `port_A_data_out`  in  32  read data, valid one cycle after the address is presented.

## Operation
- Derived values:
  - PW = SYM_W+CNT_W (pair width).
  - PPW = 32/PW (pairs per output word).
  - SPW = 32/SYM_W (symbols per input word).
  - MAXC = 2^CNT_W-1 (largest count).
- Input symbol order is little-endian: symbol i of a word is bits [i*SYM_W +: SYM_W]. Only `message_size*8/SYM_W` symbols are consumed; the unused upper symbols of the last word are ignored.
- Pair format is `{symbol, count}`, with the symbol in the upper SYM_W bits of the pair. Pair k of an output word sits at bits [k*PW +: PW]. Count range is 1..MAXC; a count of 0 is never written.
- Run rules, applied per symbol:
  - No open run: open one with count 1.
  - Same symbol and count < MAXC: increment the count.
  - Otherwise: close the open run into the packer and open a new run with count 1.
- After the last symbol, the open run is closed.
- The packer emits a word when PPW pairs have accumulated. At the end of the frame, a partially filled word is written with its unused pairs set to 0.
- FSM states:
  - IDLE: on `start`, go to FETCH, or to FIN if `message_size`==0.
  - FETCH: drive the read address.
  - LOAD: capture `port_A_data_out`; read address += 4.
  - SCAN: process one symbol per cycle. A full packer goes to EMIT. An exhausted word goes to FETCH. The last symbol goes to FLUSH.
  - EMIT: assert `port_A_we` at the write address; write address += 4; `rle_size` += 4; return to SCAN or FETCH.
  - FLUSH: close the final run; write the partial word if the packer is non-empty.
  - FIN: set `done`; clear `busy`; go to IDLE.
- Reset values: every output, register and FSM state is 0/IDLE. This includes `rle_size`, `done`, `busy`, `port_A_we`, `port_A_addr` and `port_A_data_in`.

## Timing
- `start` is accepted at edge T. FETCH occurs at T+1 with `port_A_addr=message_addr[ADDR_W-1:0]`. LOAD occurs at T+2. The first symbol is scanned at T+3.
- Throughput is one symbol per cycle in SCAN. Each input word costs 2 extra cycles (FETCH, LOAD) and each output word costs 1 extra cycle (EMIT).
- `port_A_we` is high only in EMIT/FLUSH write cycles, with `port_A_addr` and `port_A_data_in` valid in the same cycle. Reads and writes never overlap.
- `done` rises the cycle after the last write, or 2 cycles after `start` for a zero-size frame. It falls the cycle after the next accepted `start`.
- `start` while busy is ignored.
- Saturation: a run of length L produces floor(L/MAXC) pairs with count MAXC, plus one pair with the remainder if it is non-zero.
- Reset mid-operation: all state returns to reset values immediately. No further write strobes occur; memory contents already written are undefined as a frame.
- Address arithmetic is modulo 2^ADDR_W (wraps silently).

## Structure
- Package `rle_pkg` contains:
  - the FSM state enum;
  - `WORD_W=32`;
  - functions deriving PW, PPW, SPW and MAXC;
  - the parameter-legality check.
- Sub-module `rle_packer`: accumulates pairs into a 32-bit word and provides full and non-empty flags plus a zero-padded output. `rle_enc` holds the FSM, run tracker and address counters.

## Test plan
- Default parameters, `message_size`=4, word 0x41414141, `rle_addr`=0x100 -> one write 0x00004104 @0x100; `rle_size`=4; `done`=1.
- Word 0x44332211, size 4 -> writes 0x22011101 @0x100 and 0x44013301 @0x104; `rle_size`=8.
- 300 bytes of 0xAA -> single write 0xAA2DAAFF (counts 255 + 45); `rle_size`=4.
- Size 1, word 0xFFFFFFAB -> 0x0000AB01 (upper bytes ignored, pad zero). Size 0 -> `done` 2 cycles after `start`, no `port_A_we`, `rle_size`=0.
- SYM_W=16, CNT_W=16, words 0x00050005, 0x00000007, size 6 -> writes 0x00050002, then 0x00070001.
- `nreset` low during SCAN -> outputs 0 and no writes. A second `start` while busy is ignored. Restart after `done` -> `done` drops and the new frame encodes correctly.
